// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared types and constants for the register-file UART dump.
//   state_e           : serializer/dump phase encoding (IDLE, READ, START, DATA, STOP)
//   seq_e             : word-sequencer phases owned by the top level
//   DEF_CLK_DIV       : default clocks per UART bit (50 MHz / 115200)
//   BYTES_PER_WORD    : bytes per default-width register word
//   UART_FRAME_BITS   : start + 8 data + stop
//   bytes_per_word()  : bytes per word for an arbitrary data width
package rf_dump_pkg;

   localparam int unsigned DEF_CLK_DIV     = 434;
   localparam int unsigned BYTES_PER_WORD  = 4;
   localparam int unsigned DEF_WIDTH       = 8 * BYTES_PER_WORD;
   localparam int unsigned UART_FRAME_BITS = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } state_e;

   // Top-level view: IDLE, one READ cycle, then SEND while the serializer is busy
   typedef enum logic [1:0] {
      SQ_IDLE = 2'd0,
      SQ_READ = 2'd1,
      SQ_SEND = 2'd2
   } seq_e;

   function automatic int unsigned bytes_per_word(input int unsigned w);
      return w / 8;
   endfunction

endpackage

// File: rtl/rf_dump_tx_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer with a valid/ready byte input.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   valid : byte offered on data
//   data  : byte to transmit, LSB first
//   ready : registered; high in the cycle a new byte can be accepted
//           (idle, or the final cycle of a stop bit, so frames run back-to-back)
//   txd   : registered UART line, idles high
module uart_tx_byte
   import rf_dump_pkg::*;
#(
   parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       ready,
   output logic       txd
);

   localparam int unsigned TW        = $clog2(CLK_DIV);
   localparam logic [TW-1:0] LAST_TICK = TW'(CLK_DIV - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(UART_FRAME_BITS - 3);

   state_e        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          txd_q, txd_d;
   logic          ready_q, ready_d;
   logic          last_tick_c;
   logic          accept_c;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         txd_q   <= 1'b1;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         txd_q   <= txd_d;
         ready_q <= ready_d;
      end
   end

   // Frame sequencing; the bit timer restarts at 0 on every state entry
   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q + TW'(1);
      bit_d       = bit_q;
      sh_d        = sh_q;
      txd_d       = txd_q;
      last_tick_c = (tick_q == LAST_TICK);
      accept_c    = valid && ready_q;

      case (state_q)
         ST_IDLE: begin
            tick_d = '0;
            txd_d  = 1'b1;
            if (accept_c) begin
               sh_d    = data;
               state_d = ST_START;
               txd_d   = 1'b0;
            end
         end
         ST_START: begin
            if (last_tick_c) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
               txd_d   = sh_q[0];
            end
         end
         ST_DATA: begin
            if (last_tick_c) begin
               tick_d = '0;
               if (bit_q == LAST_BIT) begin
                  state_d = ST_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  sh_d  = {1'b0, sh_q[7:1]};
                  txd_d = sh_q[1];
               end
            end
         end
         ST_STOP: begin
            if (last_tick_c) begin
               tick_d = '0;
               if (accept_c) begin
                  sh_d    = data;
                  state_d = ST_START;
                  txd_d   = 1'b0;
               end else begin
                  state_d = ST_IDLE;
                  txd_d   = 1'b1;
               end
            end
         end
         default: begin
            tick_d  = '0;
            state_d = ST_IDLE;
            txd_d   = 1'b1;
         end
      endcase

      // ready is registered, so derive it from where the frame will be next cycle
      ready_d = (state_d == ST_IDLE) || ((state_d == ST_STOP) && (tick_d == LAST_TICK));
   end

   assign ready = ready_q;
   assign txd   = txd_q;

endmodule

// File: rtl/rf_dump_tx.sv
// rf_dump_tx: walks register indices 0..num-1 on a start pulse, snapshots each
// word and sends it MSB byte first as 8N1 UART frames on txd.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   start   : dump request, sampled only while idle
//   rd_addr : register index to the register-file read port (always idx)
//   rd_data : combinational read data for rd_addr
//   busy    : registered; high for the whole dump
//   done    : registered one-cycle pulse after the last stop bit
//   txd     : registered UART line, idles high
module rf_dump_tx
   import rf_dump_pkg::*;
#(
   parameter int unsigned width     = DEF_WIDTH,
   parameter int unsigned AddrWidth = 5,
   parameter int unsigned num       = 32,
   parameter int unsigned CLK_DIV   = DEF_CLK_DIV
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [AddrWidth-1:0] rd_addr,
   input  logic [width-1:0]     rd_data,
   output logic                 busy,
   output logic                 done,
   output logic                 txd
);

   localparam int unsigned BPW = bytes_per_word(width);
   localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [AddrWidth-1:0] LAST_IDX  = AddrWidth'(num - 1);
   localparam logic [BCW-1:0]       LAST_BYTE = BCW'(BPW - 1);

   seq_e                 state_q, state_d;
   logic [AddrWidth-1:0] idx_q, idx_d;
   logic [width-1:0]     word_q, word_d;
   logic [BCW-1:0]       bcnt_q, bcnt_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [width-1:0]     sel_word_c;
   logic [width-1:0]     shifted_c;
   logic [BCW-1:0]       sel_k_c;
   logic                 tx_valid_c;
   logic [7:0]           tx_byte_c;
   logic                 tx_ready;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= SQ_IDLE;
         idx_q   <= '0;
         word_q  <= '0;
         bcnt_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         bcnt_q  <= bcnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Word/byte sequencing; bcnt is the byte currently on the wire
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      word_d     = word_q;
      bcnt_d     = bcnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      tx_valid_c = 1'b0;
      sel_word_c = word_q;
      sel_k_c    = bcnt_q + BCW'(1);

      case (state_q)
         SQ_IDLE: begin
            if (start) begin
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = SQ_READ;
            end
         end
         SQ_READ: begin
            // Byte 0 comes straight from rd_data so the first start bit follows READ
            word_d     = rd_data;
            bcnt_d     = '0;
            tx_valid_c = 1'b1;
            sel_word_c = rd_data;
            sel_k_c    = '0;
            state_d    = SQ_SEND;
         end
         SQ_SEND: begin
            if (bcnt_q != LAST_BYTE) begin
               tx_valid_c = 1'b1;
               if (tx_ready) begin
                  bcnt_d = bcnt_q + BCW'(1);
               end
            end else if (tx_ready) begin
               if (idx_q != LAST_IDX) begin
                  idx_d   = idx_q + AddrWidth'(1);
                  state_d = SQ_READ;
               end else begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = SQ_IDLE;
               end
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = SQ_IDLE;
         end
      endcase

      shifted_c = sel_word_c << (32'(sel_k_c) * 32'd8);
      tx_byte_c = shifted_c[width-1 -: 8];
   end

   uart_tx_byte #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clk   (clk),
      .reset (reset),
      .valid (tx_valid_c),
      .data  (tx_byte_c),
      .ready (tx_ready),
      .txd   (txd)
   );

   assign rd_addr = idx_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_rf_dump_tx.sv
// tb_rf_dump_tx: directed bench for rf_dump_tx with a register-file model,
// a UART 8N1 decoder and a byte scoreboard.
module tb_rf_dump_tx;

   localparam int unsigned CDIV  = 4;
   localparam int unsigned NREG  = 32;
   localparam int unsigned NBYTE = NREG * 4;
   localparam int unsigned BUSY_LEN = NREG * (1 + 10 * 4 * CDIV);

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        busy;
   logic        done;
   logic        txd;

   logic [31:0] rf [NREG];
   logic [7:0]  exp_q [$];
   logic [7:0]  rx_q  [$];

   int n_cmp;
   int n_err;

   assign rd_data = rf[rd_addr];

   rf_dump_tx #(
      .width     (32),
      .AddrWidth (5),
      .num       (NREG),
      .CLK_DIV   (CDIV)
   ) dut (
      .clk     (clk),
      .reset   (rst_n),
      .start   (start),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy),
      .done    (done),
      .txd     (txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // UART decoder: samples each bit in its middle cycle, on the falling clock edge
   logic       d_act;
   int         d_cnt;
   logic [7:0] d_sh;
   always @(negedge clk) begin
      if (!rst_n) begin
         d_act <= 1'b0;
         d_cnt <= 0;
      end else if (!d_act) begin
         if (txd === 1'b0) begin
            d_act <= 1'b1;
            d_cnt <= 1;
         end
      end else begin
         d_cnt <= d_cnt + 1;
         if (d_cnt % CDIV == CDIV / 2) begin
            if (d_cnt / CDIV == 0 && txd !== 1'b0) d_act <= 1'b0;
            if (d_cnt / CDIV >= 1 && d_cnt / CDIV <= 8) d_sh <= {txd, d_sh[7:1]};
            if (d_cnt / CDIV == 9) begin
               rx_q.push_back(d_sh);
               d_act <= 1'b0;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic compare_bytes(input string tag);
      int i;
      check({tag, " byte_count"}, 32'(rx_q.size()), 32'(NBYTE));
      i = 0;
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         logic [7:0] e;
         logic [7:0] r;
         e = exp_q.pop_front();
         r = rx_q.pop_front();
         check($sformatf("%s byte %0d", tag, i), 32'(r), 32'(e));
         i++;
      end
      exp_q.delete();
      rx_q.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rx_q.delete();
   endtask

   // One full dump; inject adds ignored start pulses and rewrites r5 mid-word,
   // hold keeps start high to check the immediate restart after done
   task automatic run_dump(input bit inject, input bit hold, input string tag);
      int  cnt;
      int  dones;
      bit  fin;
      for (int i = 0; i < int'(NREG); i++) begin
         for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            w = rf[i];
            exp_q.push_back(w[31-8*k -: 8]);
         end
      end
      rx_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      check({tag, " busy_t1"}, 32'(busy), 32'd1);
      check({tag, " txd_read_t1"}, 32'(txd), 32'd1);
      if (!hold) start = 1'b0;
      @(posedge clk); #1;
      check({tag, " txd_fall_t2"}, 32'(txd), 32'd0);
      cnt   = 2;
      dones = 0;
      fin   = 1'b0;
      for (int c = 0; c < 6000 && !fin; c++) begin
         if (inject) begin
            start = (cnt == 50 || cnt == 3000);
            if (cnt == 5 * 161 + 60) rf[5] = 32'h5555_5555;
         end
         @(posedge clk); #1;
         if (done) dones++;
         if (busy) cnt++;
         else fin = 1'b1;
      end
      if (!hold) start = 1'b0;
      check({tag, " busy_len"}, 32'(cnt), 32'(BUSY_LEN));
      check({tag, " done_at_end"}, 32'(done), 32'd1);
      check({tag, " done_count"}, 32'(dones), 32'd1);
      compare_bytes(tag);
      @(posedge clk); #1;
      check({tag, " done_drop"}, 32'(done), 32'd0);
      if (hold) begin
         check({tag, " restart_busy"}, 32'(busy), 32'd1);
         start = 1'b0;
         do_reset();
      end else begin
         check({tag, " idle_after"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      n_cmp = 0;
      n_err = 0;
      start = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < int'(NREG); i++)
         rf[i] = {8'(i), 8'(8'hA5 ^ 8'(i)), 8'(i * 7), 8'(~i)};
      rf[0] = 32'h0000_0000;
      rf[5] = 32'hAAAA_AAAA;
      rf[8] = 32'h1234_5678;
      do_reset();

      // Quiet after reset
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         check($sformatf("idle cycle %0d", c), {24'd0, txd, busy, done, rd_addr}, {24'd0, 1'b1, 1'b0, 1'b0, 5'd0});
      end

      run_dump(1'b0, 1'b0, "plain");
      run_dump(1'b1, 1'b0, "inject");
      rf[5] = 32'hAAAA_AAAA;

      // Abort during r3's first byte data bits
      rx_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 1;
      while (cnt < 500) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("abort rd_addr_r3", 32'(rd_addr), 32'd3);
      check("abort rx_before", 32'(rx_q.size()), 32'd12);
      rst_n = 1'b0;
      #1;
      check("abort txd_async", 32'(txd), 32'd1);
      check("abort busy_async", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      rx_q.delete();
      @(posedge clk); #1;
      check("abort rd_addr_after", 32'(rd_addr), 32'd0);
      check("abort busy_after", 32'(busy), 32'd0);
      check("abort txd_after", 32'(txd), 32'd1);

      run_dump(1'b0, 1'b1, "after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
